// File: rtl/iol_align_pkg.sv
// Shared types for the IDDRX2F word-alignment controller.
// Holds the FSM state encoding and the slip counter width.
package iol_align_pkg;

  localparam int SLIP_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_SLIP,
    S_LOCK,
    S_FAIL
  } align_state_t;

endpackage

// File: rtl/iddrx2_align_ctrl.sv
// IDDRX2F word aligner: slips ALIGNWD until Q matches PATTERN.
// In: SCLK RST START Q[3:0]; out: ALIGNWD BUSY LOCKED FAIL SLIP_COUNT.
module iddrx2_align_ctrl
  import iol_align_pkg::*;
#(
  parameter logic [3:0] PATTERN       = 4'b1100,
  parameter int         SETTLE_CYCLES = 4,
  parameter int         MATCH_COUNT   = 8,
  parameter int         MAX_SLIPS     = 3,
  parameter int         LOSS_THRESH   = 2
) (
  input  logic              SCLK,
  input  logic              RST,
  input  logic              START,
  input  logic [3:0]        Q,
  output logic              ALIGNWD,
  output logic              BUSY,
  output logic              LOCKED,
  output logic              FAIL,
  output logic [SLIP_W-1:0] SLIP_COUNT
);

  localparam logic [7:0] SETTLE_L = 8'(SETTLE_CYCLES);
  localparam logic [7:0] MATCH_L  = 8'(MATCH_COUNT);
  localparam logic [7:0] LOSS_L   = 8'(LOSS_THRESH);
  localparam logic [SLIP_W-1:0] MAX_L = SLIP_W'(MAX_SLIPS);

  align_state_t      state_q, state_d;
  logic [7:0]        settle_q, settle_d;
  logic [7:0]        match_q, match_d;
  logic [7:0]        loss_q, loss_d;
  logic [SLIP_W-1:0] slip_q, slip_d;
  logic              hit;
  logic              restart;

  assign hit = (Q == PATTERN);

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    match_d  = match_q;
    loss_d   = loss_q;
    slip_d   = slip_q;
    restart  = 1'b0;
    unique case (state_q)
      S_IDLE, S_FAIL: begin
        restart = START;
      end
      S_SETTLE: begin
        if (settle_q <= 8'd1) begin
          state_d  = S_CHECK;
          settle_d = 8'd0;
          match_d  = 8'd0;
        end else begin
          settle_d = settle_q - 8'd1;
        end
      end
      S_CHECK: begin
        if (hit) begin
          match_d = match_q + 8'd1;
          if (match_q + 8'd1 == MATCH_L) begin
            state_d = S_LOCK;
            loss_d  = 8'd0;
          end
        end else if (slip_q == MAX_L) begin
          state_d = S_FAIL;
        end else begin
          state_d = S_SLIP;
        end
      end
      S_SLIP: begin
        if (slip_q != '1) slip_d = slip_q + 1'b1;
        settle_d = SETTLE_L;
        state_d  = S_SETTLE;
      end
      S_LOCK: begin
        // START and a loss event both restart; START has priority
        if (START) begin
          restart = 1'b1;
        end else if (hit) begin
          loss_d = 8'd0;
        end else if (loss_q + 8'd1 == LOSS_L) begin
          restart = 1'b1;
        end else begin
          loss_d = loss_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (restart) begin
      state_d  = S_SETTLE;
      settle_d = SETTLE_L;
      match_d  = 8'd0;
      loss_d   = 8'd0;
      slip_d   = '0;
    end
  end

  always_ff @(posedge SCLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      settle_q <= 8'd0;
      match_q  <= 8'd0;
      loss_q   <= 8'd0;
      slip_q   <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      match_q  <= match_d;
      loss_q   <= loss_d;
      slip_q   <= slip_d;
    end
  end

  assign ALIGNWD    = (state_q == S_SLIP);
  assign BUSY       = (state_q == S_SETTLE) ||
                      (state_q == S_CHECK)  ||
                      (state_q == S_SLIP);
  assign LOCKED     = (state_q == S_LOCK);
  assign FAIL       = (state_q == S_FAIL);
  assign SLIP_COUNT = slip_q;

endmodule

// File: tb/tb_iddrx2_align_ctrl.sv
// Directed bench for iddrx2_align_ctrl.
// Drives START/Q, models the ALIGNWD word rotation.
module tb_iddrx2_align_ctrl;

  logic       SCLK = 1'b0;
  logic       RST;
  logic       START;
  logic [3:0] Q;
  logic       ALIGNWD, BUSY, LOCKED, FAIL;
  logic [7:0] SLIP_COUNT;

  int   checks = 0;
  int   failures = 0;
  logic rot_en = 1'b0;
  int   pulses, min_sep, gap, dbl;
  logic prev_aw;
  int   n, k;

  always #5 SCLK = ~SCLK;

  iddrx2_align_ctrl #(
    .PATTERN(4'b1100), .SETTLE_CYCLES(4), .MATCH_COUNT(8),
    .MAX_SLIPS(3), .LOSS_THRESH(2)
  ) dut (
    .SCLK(SCLK), .RST(RST), .START(START), .Q(Q),
    .ALIGNWD(ALIGNWD), .BUSY(BUSY), .LOCKED(LOCKED),
    .FAIL(FAIL), .SLIP_COUNT(SLIP_COUNT)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clr_mon();
    pulses = 0; min_sep = 1000; gap = 0; dbl = 0; prev_aw = 1'b0;
  endtask

  task automatic tick();
    @(posedge SCLK); #1;
    if (ALIGNWD) begin
      pulses++;
      if (prev_aw) dbl++;
      if (pulses > 1 && gap + 1 < min_sep) min_sep = gap + 1;
      gap = 0;
    end else begin
      gap++;
    end
    prev_aw = ALIGNWD;
    if (rot_en && ALIGNWD) Q = {Q[2:0], Q[3]};
  endtask

  task automatic start_pulse();
    START = 1'b1; tick(); START = 1'b0;
  endtask

  task automatic wait_lock(input int max, output int cnt);
    cnt = 0;
    while (!LOCKED && cnt < max) begin tick(); cnt++; end
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; Q = 4'b1100;
    clr_mon();
    #12;
    chk("rst_alignwd", ALIGNWD, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_locked", LOCKED, 0);
    chk("rst_fail", FAIL, 0);
    chk("rst_slipcnt", SLIP_COUNT, 0);
    RST = 1'b0;
    tick(); tick();
    chk("idle_no_start", BUSY, 0);

    start_pulse();
    chk("aligned_busy", BUSY, 1);
    wait_lock(40, n);
    chk("aligned_lat", n, 12);
    chk("aligned_pulses", pulses, 0);
    chk("aligned_slipcnt", SLIP_COUNT, 0);

    Q = 4'b0000; tick();
    Q = 4'b1100; tick();
    chk("one_miss_hold", LOCKED, 1);
    Q = 4'b0000; tick();
    chk("miss1_hold", LOCKED, 1);
    tick();
    chk("loss_unlock", LOCKED, 0);
    chk("loss_busy", BUSY, 1);
    Q = 4'b1100;
    wait_lock(40, n);
    chk("relock_lat", n, 12);

    start_pulse();
    tick();
    START = 1'b1; tick(); START = 1'b0;
    wait_lock(40, n);
    chk("busy_start_ignored", n, 10);

    Q = 4'b0011; rot_en = 1'b1;
    clr_mon();
    start_pulse();
    k = 0;
    while (pulses < 1 && k < 30) begin tick(); k++; end
    tick();
    START = 1'b1; tick(); START = 1'b0;
    chk("busy_start_slipcnt", SLIP_COUNT, 1);
    wait_lock(80, n);
    chk("slip2_locked", LOCKED, 1);
    chk("slip2_pulses", pulses, 2);
    chk("slip2_width", dbl, 0);
    chk("slip2_sep_ge5", min_sep >= 5, 1);
    chk("slip2_slipcnt", SLIP_COUNT, 2);
    rot_en = 1'b0;

    Q = 4'b0000; tick();
    START = 1'b1; tick(); START = 1'b0;
    chk("collide_busy", BUSY, 1);
    chk("collide_slipcnt", SLIP_COUNT, 0);
    Q = 4'b1100;
    wait_lock(40, n);
    chk("collide_one_settle", n, 12);

    Q = 4'b1010;
    clr_mon();
    start_pulse();
    k = 0;
    while (!FAIL && k < 100) begin tick(); k++; end
    chk("never_fail", FAIL, 1);
    chk("never_pulses", pulses, 3);
    chk("never_slipcnt", SLIP_COUNT, 3);
    chk("never_busy", BUSY, 0);
    chk("never_width", dbl, 0);
    tick(); tick();
    chk("fail_held", FAIL, 1);
    start_pulse();
    chk("restart_fail_clr", FAIL, 0);
    chk("restart_slipcnt", SLIP_COUNT, 0);
    chk("restart_busy", BUSY, 1);

    k = 0;
    while (!ALIGNWD && k < 40) begin tick(); k++; end
    chk("found_slip", ALIGNWD, 1);
    #2 RST = 1'b1;
    #1;
    chk("async_alignwd", ALIGNWD, 0);
    chk("async_busy", BUSY, 0);
    chk("async_locked", LOCKED, 0);
    chk("async_fail", FAIL, 0);
    chk("async_slipcnt", SLIP_COUNT, 0);
    #1 RST = 1'b0;
    tick(); tick();
    chk("idle_after_rst", BUSY, 0);
    Q = 4'b1100;
    start_pulse();
    wait_lock(40, n);
    chk("post_rst_lat", n, 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
